// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared constants and types for the four-FIFO round-robin scheduler.
// Word selection from the packed upstream data bus lives here so every user slices it the same way.
package fifo_rr_scheduler_pkg;

    localparam int DATA_WIDTH = 32'sd10;
    localparam int NUM_FIFOS  = 32'sd4;
    localparam int THR_WIDTH  = 32'sd3;

    localparam logic [THR_WIDTH-1:0] ALTO_DEFAULT = 3'd6;
    localparam logic [THR_WIDTH-1:0] BAJO_DEFAULT = 3'd1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    function automatic logic [DATA_WIDTH-1:0] select_word(
        input logic [NUM_FIFOS*DATA_WIDTH-1:0] bus_words,
        input logic [1:0]                      idx
    );
        return bus_words[32'(idx) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Upstream FIFO bank and downstream FIFO signals seen by the scheduler.
// The master side is the scheduler; the slave side is the FIFO bank.
interface fifo_rr_scheduler_if;
    import fifo_rr_scheduler_pkg::*;

    logic [NUM_FIFOS-1:0]            empty_vec;
    logic [NUM_FIFOS-1:0]            error_vec;
    logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data_in;
    logic                            down_almost_full;
    logic                            down_full;
    logic [NUM_FIFOS-1:0]            pop_vec;
    logic                            push_out;
    logic [DATA_WIDTH-1:0]           data_out;

    modport master (
        input  empty_vec, error_vec, fifo_data_in, down_almost_full, down_full,
        output pop_vec, push_out, data_out
    );

    modport slave (
        output empty_vec, error_vec, fifo_data_in, down_almost_full, down_full,
        input  pop_vec, push_out, data_out
    );

endinterface

// File: rtl/fifo_rr_scheduler_rr_arbiter_4.sv
// Combinational four-way round-robin arbiter.
// The search starts one past the previous winner and wraps modulo four.
module rr_arbiter_4
    import fifo_rr_scheduler_pkg::*;
(
    input  logic [NUM_FIFOS-1:0] req,
    input  logic                 en,
    input  logic [1:0]           last,
    output logic [NUM_FIFOS-1:0] grant,
    output logic [1:0]           grant_idx
);

    logic [1:0] cand_s;
    logic       found_s;

    // First requester after last wins; nothing is granted when disabled.
    always_comb begin
        grant     = {NUM_FIFOS{1'b0}};
        grant_idx = 2'd0;
        found_s   = 1'b0;
        cand_s    = 2'd0;
        for (int k = 32'sd1; k <= NUM_FIFOS; k++) begin
            cand_s = last + 2'(k);
            if (en && !found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Configuration FSM, threshold latch and round-robin pop/push forwarding
// from four upstream FIFOs into one downstream FIFO.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [THR_WIDTH-1:0]  alto_in,
    input  logic [THR_WIDTH-1:0]  bajo_in,
    fifo_rr_scheduler_if.master   bus,
    output logic [THR_WIDTH-1:0]  alto,
    output logic [THR_WIDTH-1:0]  bajo,
    output logic [2:0]            state,
    output logic                  idle,
    output logic                  error_out
);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [1:0]             last_r;
    logic [1:0]             idx_r;
    logic                   push_r;
    logic                   error_r;
    logic [THR_WIDTH-1:0]   alto_r;
    logic [THR_WIDTH-1:0]   bajo_r;
    logic [NUM_FIFOS-1:0]   req_s;
    logic [NUM_FIFOS-1:0]   grant_s;
    logic [1:0]             grant_idx_s;
    logic                   any_req_s;
    logic                   err_cond_s;
    logic                   pop_en_s;
    logic                   pop_any_s;

    assign req_s      = ~bus.empty_vec;
    assign any_req_s  = |req_s;
    assign err_cond_s = (|bus.error_vec) || (push_r && bus.down_full);
    // Pops are combinational so an empty flag seen this cycle can never be popped.
    assign pop_en_s   = (state_r == ST_ACTIVE) && !init && !bus.down_almost_full && !err_cond_s;
    assign pop_any_s  = |grant_s;

    rr_arbiter_4 u_arb (
        .req       (req_s),
        .en        (pop_en_s),
        .last      (last_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Next-state decode: error beats init, init beats arbitration.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RESET: state_nxt_s = ST_INIT;
            ST_INIT: begin
                if (err_cond_s)      state_nxt_s = ST_ERROR;
                else if (init)       state_nxt_s = ST_INIT;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (err_cond_s)      state_nxt_s = ST_ERROR;
                else if (init)       state_nxt_s = ST_INIT;
                else if (any_req_s)  state_nxt_s = ST_ACTIVE;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (err_cond_s)                  state_nxt_s = ST_ERROR;
                else if (init)                   state_nxt_s = push_r ? ST_ACTIVE : ST_INIT;
                else if (!any_req_s && !push_r)  state_nxt_s = ST_IDLE;
                else                             state_nxt_s = ST_ACTIVE;
            end
            ST_ERROR: state_nxt_s = ST_ERROR;
            default:  state_nxt_s = ST_ERROR;
        endcase
    end

    // State, grant pointer, in-flight push and threshold registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RESET;
            last_r  <= 2'd3;
            idx_r   <= 2'd0;
            push_r  <= 1'b0;
            error_r <= 1'b0;
            alto_r  <= ALTO_DEFAULT;
            bajo_r  <= BAJO_DEFAULT;
        end else begin
            state_r <= state_nxt_s;
            push_r  <= pop_any_s;
            if (pop_any_s) begin
                last_r <= grant_idx_s;
                idx_r  <= grant_idx_s;
            end
            if (state_nxt_s == ST_ERROR) begin
                error_r <= 1'b1;
            end
            if ((state_r == ST_INIT) && init && !err_cond_s) begin
                alto_r <= alto_in;
                bajo_r <= bajo_in;
            end
        end
    end

    assign bus.pop_vec  = grant_s;
    assign bus.push_out = push_r;
    assign bus.data_out = push_r ? select_word(bus.fifo_data_in, idx_r) : {DATA_WIDTH{1'b0}};
    assign alto         = alto_r;
    assign bajo         = bajo_r;
    assign state        = state_r;
    assign idle         = (state_r == ST_IDLE);
    assign error_out    = error_r;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench for fifo_rr_scheduler: a reference round-robin model predicts pops,
// queues the expected words, and checks each push one cycle later.
module tb_fifo_rr_scheduler;
    import fifo_rr_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic [2:0] alto_in = 3'd0;
    logic [2:0] bajo_in = 3'd0;
    logic [2:0] alto, bajo, state;
    logic       idle, error_out;

    int         vectors = 0;
    int         miscompares = 0;
    int         n_pop_exp = 0;
    int         n_push_obs = 0;
    logic [1:0] m_last;
    logic [9:0] m_data [4];
    logic [9:0] sb_q [$];

    fifo_rr_scheduler_if bus();

    fifo_rr_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .alto_in   (alto_in),
        .bajo_in   (bajo_in),
        .bus       (bus),
        .alto      (alto),
        .bajo      (bajo),
        .state     (state),
        .idle      (idle),
        .error_out (error_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One scheduler cycle: predict the pop, compare, then check the push after the edge.
    task automatic run_cycle(input bit allow, input logic next_daf);
        logic [3:0] exp_g;
        logic [9:0] exp_d;
        int         idx;
        bit         pend;
        exp_g = 4'b0000;
        pend  = 1'b0;
        idx   = 0;
        if (allow && !bus.down_almost_full && bus.error_vec == 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (!pend && !bus.empty_vec[(int'(m_last) + k) % 4]) begin
                    idx  = (int'(m_last) + k) % 4;
                    pend = 1'b1;
                end
            end
        end
        if (pend) begin
            exp_g[idx] = 1'b1;
            m_last     = 2'(idx);
            sb_q.push_back(m_data[idx]);
            n_pop_exp++;
        end
        vectors++;
        if (bus.pop_vec !== exp_g) begin
            miscompares++;
            $display("FAIL pop_vec: got %b want %b", bus.pop_vec, exp_g);
        end
        @(posedge clk); #1;
        bus.down_almost_full = next_daf;
        #1;
        vectors++;
        if (bus.push_out !== pend) begin
            miscompares++;
            $display("FAIL push_out: got %b want %b", bus.push_out, pend);
        end
        if (bus.push_out === 1'b1) n_push_obs++;
        if (pend) begin
            exp_d = sb_q.pop_front();
            vectors++;
            if (bus.data_out !== exp_d || idle !== 1'b0) begin
                miscompares++;
                $display("FAIL push_data: got %h idle %b want %h idle 0", bus.data_out, idle, exp_d);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        init  = 1'b0;
        m_data[0] = 10'h300; m_data[1] = 10'h011; m_data[2] = 10'h122; m_data[3] = 10'h033;
        bus.fifo_data_in     = {m_data[3], m_data[2], m_data[1], m_data[0]};
        bus.empty_vec        = 4'b1111;
        bus.error_vec        = 4'b0000;
        bus.down_almost_full = 1'b0;
        bus.down_full        = 1'b0;
        m_last = 2'd3;
        #12;
        vectors++;
        if ({state, alto, bajo, idle, error_out} !== {3'd0, 3'd6, 3'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_cfg: got st %0d alto %0d bajo %0d idle %b err %b want 0 6 1 0 0",
                     state, alto, bajo, idle, error_out);
        end
        vectors++;
        if ({bus.pop_vec, bus.push_out, bus.data_out} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got pop %b push %b data %h want all zero",
                     bus.pop_vec, bus.push_out, bus.data_out);
        end
    endtask

    task automatic test_init();
        reset = 1'b1; init = 1'b1; alto_in = 3'd5; bajo_in = 3'd2;
        @(posedge clk); #1;
        vectors++;
        if (state !== 3'd1) begin
            miscompares++;
            $display("FAIL init_enter: got state %0d want 1", state);
        end
        @(posedge clk); #1;
        vectors++;
        if ({state, alto, bajo} !== {3'd1, 3'd5, 3'd2}) begin
            miscompares++;
            $display("FAIL init_load: got st %0d alto %0d bajo %0d want 1 5 2", state, alto, bajo);
        end
        init = 1'b0; alto_in = 3'd7; bajo_in = 3'd7;
        @(posedge clk); #1;
        vectors++;
        if ({state, idle, alto, bajo} !== {3'd2, 1'b1, 3'd5, 3'd2}) begin
            miscompares++;
            $display("FAIL init_idle: got st %0d idle %b alto %0d bajo %0d want 2 1 5 2", state, idle, alto, bajo);
        end
    endtask

    task automatic test_rr_two();
        bus.empty_vec = 4'b0101;
        #1;
        run_cycle(1'b0, 1'b0);
        vectors++;
        if (state !== 3'd3) begin
            miscompares++;
            $display("FAIL rr_two_active: got state %0d want 3", state);
        end
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        bus.empty_vec = 4'b0000;
        #1;
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0);
        vectors++;
        if (n_push_obs !== n_pop_exp) begin
            miscompares++;
            $display("FAIL push_count: got %0d pushes want %0d", n_push_obs, n_pop_exp);
        end
    endtask

    task automatic test_backpressure();
        bus.empty_vec = 4'b1011;
        #1;
        run_cycle(1'b1, 1'b1);
        bus.empty_vec = 4'b0000;
        #1;
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);
        vectors++;
        if (state !== 3'd3) begin
            miscompares++;
            $display("FAIL bp_hold_active: got state %0d want 3", state);
        end
        run_cycle(1'b1, 1'b0);
        bus.empty_vec = 4'b1111;
        #1;
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        vectors++;
        if ({state, idle} !== {3'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL drain_idle: got st %0d idle %b want 2 1", state, idle);
        end
    endtask

    task automatic test_error();
        bus.empty_vec = 4'b0000;
        #1;
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        bus.error_vec = 4'b0100;
        #1;
        run_cycle(1'b0, 1'b0);
        vectors++;
        if ({state, error_out, bus.pop_vec, bus.push_out} !== {3'd4, 1'b1, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL error_enter: got st %0d err %b pop %b push %b want 4 1 0000 0",
                     state, error_out, bus.pop_vec, bus.push_out);
        end
        bus.error_vec = 4'b0000;
        init = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if ({state, error_out, bus.pop_vec, bus.push_out} !== {3'd4, 1'b1, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL error_sticky: got st %0d err %b pop %b push %b want 4 1 0000 0",
                     state, error_out, bus.pop_vec, bus.push_out);
        end
        init = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        vectors++;
        if ({state, error_out} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL error_clear: got st %0d err %b want 0 0", state, error_out);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.empty_vec = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if ({state, bus.pop_vec} !== {3'd3, 4'b0001}) begin
            miscompares++;
            $display("FAIL mid_pop: got st %0d pop %b want 3 0001", state, bus.pop_vec);
        end
        @(posedge clk); #1;
        vectors++;
        if ({bus.push_out, bus.data_out} !== {1'b1, 10'h300}) begin
            miscompares++;
            $display("FAIL mid_push: got push %b data %h want 1 300", bus.push_out, bus.data_out);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({state, bus.pop_vec, bus.push_out, bus.data_out, alto, bajo} !== {3'd0, 4'b0000, 1'b0, 10'h000, 3'd6, 3'd1}) begin
            miscompares++;
            $display("FAIL async_reset: got st %0d pop %b push %b data %h alto %0d bajo %0d want 0 0000 0 000 6 1",
                     state, bus.pop_vec, bus.push_out, bus.data_out, alto, bajo);
        end
        bus.empty_vec = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.push_out !== 1'b0) begin
                miscompares++;
                $display("FAIL push_after_reset: got %b want 0 at cycle %0d", bus.push_out, i);
            end
        end
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: got %0d entries want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_rr_two();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
